iob_soc_sut_axis_src: RTL and testbench



---
 rtl/iob_soc_sut_axis_src_pkg.sv | 21 ++
 rtl/iob_soc_sut_axis_src_fifo.sv | 65 ++++++
 rtl/iob_soc_sut_axis_src.sv | 169 ++++++++++++++++
 tb/tb_iob_soc_sut_axis_src.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_soc_sut_axis_src_pkg.sv
// Shared definitions for the testbench AXI-Stream source: register indices, STATUS layout,
// FIFO entry width. Optional pattern engine is enabled by IOB_SOC_SUT_AXIS_SRC_PATTERN_EN.
package iob_soc_sut_axis_src_pkg;

  localparam logic [2:0] REG_DATA      = 3'd0;
  localparam logic [2:0] REG_DATA_LAST = 3'd1;
  localparam logic [2:0] REG_STATUS    = 3'd2;
  localparam logic [2:0] REG_COUNT     = 3'd3;
  localparam logic [2:0] REG_PATTERN   = 3'd4;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_LEVEL_LSB = 2;
  localparam int STATUS_BUSY_BIT  = 31;

  // Each FIFO entry carries tlast above the data word.
  function automatic int entry_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_soc_sut_axis_src_fifo.sv
// Synchronous FIFO with a registered read port; pop_data doubles as the AXIS output register.
// Level, full and empty are registered and count stored entries only.
module iob_soc_sut_axis_src_fifo #(
  parameter int W      = 33,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W-1:0]      push_data,
  input  logic              pop,
  output logic [W-1:0]      pop_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [ADDR_W:0]   level_nxt;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    level_nxt = level;
    if (do_push & ~do_pop)
      level_nxt = level + (ADDR_W + 1)'(1);
    else if (do_pop & ~do_push)
      level_nxt = level - (ADDR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      pop_data <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        pop_data <= mem[rd_ptr];
      end
      level <= level_nxt;
      full  <= (level_nxt == LEVEL_FULL);
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/iob_soc_sut_axis_src.sv
// AXI-Stream source driven through an IOb native slave: buffered beats, status and beat counter.
// Define IOB_SOC_SUT_AXIS_SRC_PATTERN_EN to add the counting-pattern engine on register 4.
module iob_soc_sut_axis_src
  import iob_soc_sut_axis_src_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int FIFO_ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_rvalid_o,
  output logic                iob_ready_o,
  output logic [DATA_W-1:0]   axis_tdata_o,
  output logic                axis_tvalid_o,
  output logic                axis_tlast_o,
  input  logic                axis_tready_i
);

  localparam int ENTRY_W = entry_w(DATA_W);

  logic [2:0]           reg_idx;
  logic                 is_write;
  logic                 host_push;
  logic                 accept;
  logic                 rd_accept;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_wdata;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic [FIFO_ADDR_W:0] fifo_level;
  logic                 tvalid_q;
  logic [31:0]          beat_cnt;
  logic [31:0]          status;
  logic [DATA_W-1:0]    rd_mux;
  logic                 pat_busy;
  logic                 unused_addr;

  assign reg_idx     = iob_addr_i[4:2];
  assign unused_addr = ^iob_addr_i;
  assign is_write    = |iob_wstrb_i;
  assign host_push   = is_write & ((reg_idx == REG_DATA) | (reg_idx == REG_DATA_LAST));

  // Stall only on registered state so a same-cycle pop never releases a full-FIFO push.
  always_comb begin
    iob_ready_o = 1'b1;
    if (iob_avalid_i & host_push & fifo_full)
      iob_ready_o = 1'b0;
    if (iob_avalid_i & is_write & pat_busy & (host_push | (reg_idx == REG_PATTERN)))
      iob_ready_o = 1'b0;
  end

  assign accept    = iob_avalid_i & iob_ready_o;
  assign rd_accept = accept & ~is_write;

`ifdef IOB_SOC_SUT_AXIS_SRC_PATTERN_EN
  logic [15:0] pat_idx;
  logic [15:0] pat_rem;
  logic [15:0] pat_n;
  logic        pat_load;
  logic        pat_push;

  assign pat_n    = 16'(iob_wdata_i);
  assign pat_load = accept & is_write & (reg_idx == REG_PATTERN) & (pat_n != '0);
  assign pat_push = pat_busy & ~fifo_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pat_busy <= 1'b0;
      pat_idx  <= '0;
      pat_rem  <= '0;
    end else if (pat_load) begin
      pat_busy <= 1'b1;
      pat_idx  <= '0;
      pat_rem  <= pat_n;
    end else if (pat_push) begin
      pat_idx <= pat_idx + 16'd1;
      pat_rem <= pat_rem - 16'd1;
      if (pat_rem == 16'd1)
        pat_busy <= 1'b0;
    end
  end

  assign fifo_push  = pat_push | (accept & host_push);
  assign fifo_wdata = pat_busy ? {pat_rem == 16'd1, DATA_W'(pat_idx)}
                               : {reg_idx == REG_DATA_LAST, iob_wdata_i};
`else
  assign pat_busy   = 1'b0;
  assign fifo_push  = accept & host_push;
  assign fifo_wdata = {reg_idx == REG_DATA_LAST, iob_wdata_i};
`endif

  // The FIFO read register is the output stage; refill it whenever it is free or draining.
  assign fifo_pop = ~tvalid_q | axis_tready_i;

  iob_soc_sut_axis_src_fifo #(
    .W      (ENTRY_W),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)
      tvalid_q <= 1'b0;
    else if (fifo_pop & ~fifo_empty)
      tvalid_q <= 1'b1;
    else if (axis_tready_i)
      tvalid_q <= 1'b0;
  end

  assign axis_tvalid_o = tvalid_q;
  assign axis_tdata_o  = fifo_rdata[DATA_W-1:0];
  assign axis_tlast_o  = fifo_rdata[DATA_W];

  // A COUNT write preloads the counter so drivers can exercise wrap-around.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      beat_cnt <= '0;
    else if (accept & is_write & (reg_idx == REG_COUNT))
      beat_cnt <= 32'(iob_wdata_i);
    else if (tvalid_q & axis_tready_i)
      beat_cnt <= beat_cnt + 32'd1;
  end

  always_comb begin
    status                                          = '0;
    status[STATUS_EMPTY_BIT]                        = fifo_empty;
    status[STATUS_FULL_BIT]                         = fifo_full;
    status[STATUS_LEVEL_LSB +: FIFO_ADDR_W + 1]     = fifo_level;
    status[STATUS_BUSY_BIT]                         = pat_busy;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_STATUS: rd_mux = status[DATA_W-1:0];
      REG_COUNT:  rd_mux = beat_cnt[DATA_W-1:0];
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iob_rvalid_o <= 1'b0;
      iob_rdata_o  <= '0;
    end else begin
      iob_rvalid_o <= rd_accept;
      if (rd_accept)
        iob_rdata_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_iob_soc_sut_axis_src.sv
// Self-checking bench for iob_soc_sut_axis_src: expected beat queue, arithmetic COUNT/STATUS model.
// Pattern-engine checks run when IOB_SOC_SUT_AXIS_SRC_PATTERN_EN is defined.
module tb_iob_soc_sut_axis_src;

  localparam logic [2:0] R_DATA = 3'd0, R_LAST = 3'd1, R_STATUS = 3'd2,
                         R_COUNT = 3'd3, R_PATTERN = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iob_avalid = 1'b0;
  logic [4:0]  iob_addr = '0;
  logic [31:0] iob_wdata = '0;
  logic [3:0]  iob_wstrb = '0;
  logic [31:0] iob_rdata;
  logic        iob_rvalid;
  logic        iob_ready;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [32:0] exp_q[$];
  int          beat_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_soc_sut_axis_src dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .iob_avalid_i  (iob_avalid),
    .iob_addr_i    (iob_addr),
    .iob_wdata_i   (iob_wdata),
    .iob_wstrb_i   (iob_wstrb),
    .iob_rdata_o   (iob_rdata),
    .iob_rvalid_o  (iob_rvalid),
    .iob_ready_o   (iob_ready),
    .axis_tdata_o  (tdata),
    .axis_tvalid_o (tvalid),
    .axis_tlast_o  (tlast),
    .axis_tready_i (tready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream monitor: in-order beat check plus hold-while-stalled check.
  logic [32:0] hold_beat;
  bit          hold_v = 0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", tvalid, 1'b1);
        chk("hold_beat", {tlast, tdata}, hold_beat);
      end
      if (tvalid && tready) begin
        beat_cyc.push_back(cyc);
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", {tlast, tdata}, e);
        end
      end
      hold_v    = tvalid && !tready;
      hold_beat = {tlast, tdata};
    end
  end

  task automatic iob_req(input logic [2:0] idx, input logic [31:0] d, input bit wr,
                         input int max_wait, output bit ok);
    iob_avalid = 1'b1;
    iob_addr   = {idx, 2'b00};
    iob_wdata  = d;
    iob_wstrb  = wr ? 4'hF : 4'h0;
    ok = 0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (iob_ready) begin
        ok = 1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    iob_avalid = 1'b0;
    iob_wstrb  = 4'h0;
  endtask

  task automatic iob_write(input logic [2:0] idx, input logic [31:0] d);
    bit ok;
    iob_req(idx, d, 1'b1, 300, ok);
    chk("wr_accept", ok, 1'b1);
    if (ok && (idx == R_DATA || idx == R_LAST))
      exp_q.push_back({idx == R_LAST, d});
`ifdef IOB_SOC_SUT_AXIS_SRC_PATTERN_EN
    if (ok && idx == R_PATTERN)
      for (int k = 0; k < int'(d[15:0]); k++)
        exp_q.push_back({k == int'(d[15:0]) - 1, 32'(k)});
`endif
  endtask

  task automatic iob_read(input logic [2:0] idx, output logic [31:0] d);
    bit ok;
    iob_req(idx, 32'h0, 1'b0, 20, ok);
    chk("rd_accept", ok, 1'b1);
    @(negedge clk);
    chk("rvalid", iob_rvalid, 1'b1);
    d = iob_rdata;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rvalid_pulse", iob_rvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int a0;
    bit wr_done;
    int exp_count;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_ready", iob_ready, 1'b1);
    chk("rst_rvalid", iob_rvalid, 1'b0);
    chk("rst_rdata", iob_rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    iob_read(R_STATUS, r); chk("rst_status", r, 32'h1);
    iob_read(R_COUNT, r);  chk("rst_count", r, 32'h0);

    // Three-beat frame, latency and back-to-back timing.
    tready = 1'b1;
    beat_cyc.delete();
    iob_write(R_DATA, 32'hA); a0 = acc_cyc;
    iob_write(R_DATA, 32'hB);
    iob_write(R_LAST, 32'hC);
    wait_drain(50);
    chk("t1_nbeats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3) begin
      chk("t1_latency", beat_cyc[0] - a0, 2);
      chk("t1_b2b", beat_cyc[2] - beat_cyc[0], 2);
    end
    exp_count = 3;
    iob_read(R_COUNT, r); chk("t1_count", r, exp_count);

    // Backpressure: output register plus 16 FIFO entries fill, next push stalls.
    tready = 1'b0;
    for (int i = 0; i < 17; i++) iob_write(R_DATA, 32'h100 + i);
    iob_read(R_STATUS, r); chk("t2_status", r, (32'd16 << 2) | 32'h2);
    iob_avalid = 1'b1; iob_addr = {R_DATA, 2'b00}; iob_wdata = 32'h200; iob_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall", iob_ready, 1'b0);
    end
    @(posedge clk); #1 tready = 1'b1;
    iob_write(R_LAST, 32'h200);
    wait_drain(100);
    exp_count += 18;
    iob_read(R_COUNT, r); chk("t2_count", r, exp_count);

    // 100-beat frame under random tready.
    wr_done = 0;
    fork
      begin
        for (int i = 0; i < 100; i++)
          iob_write((i == 99) ? R_LAST : R_DATA, $urandom);
        wr_done = 1;
      end
      begin
        while (!wr_done) begin
          @(posedge clk); #1 tready = 1'($urandom_range(0, 1));
        end
      end
    join
    tready = 1'b1;
    wait_drain(500);
    exp_count += 100;
    iob_read(R_COUNT, r); chk("t3_count", r, exp_count);

    // Counter wrap.
    iob_write(R_COUNT, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) iob_write((i == 2) ? R_LAST : R_DATA, 32'h300 + i);
    wait_drain(50);
    iob_read(R_COUNT, r); chk("t4_count_wrap", r, 32'h1);

    // Unmapped registers.
    iob_read(3'd5, r); chk("t5_unmapped_rd", r, 32'h0);
    iob_write(3'd6, 32'hDEAD);
    iob_read(R_STATUS, r); chk("t5_status", r, 32'h1);

`ifdef IOB_SOC_SUT_AXIS_SRC_PATTERN_EN
    iob_write(R_PATTERN, 32'd4);
    iob_avalid = 1'b1; iob_addr = {R_DATA, 2'b00}; iob_wdata = 32'h55; iob_wstrb = 4'hF;
    @(negedge clk);
    chk("t6_busy_stall", iob_ready, 1'b0);
    @(posedge clk); #1;
    iob_write(R_DATA, 32'h55);
    wait_drain(50);
    iob_write(R_PATTERN, 32'd0);
    iob_read(R_STATUS, r); chk("t6_n0_status", r, 32'h1);
    tready = 1'b0;
    iob_write(R_PATTERN, 32'd20);
    repeat (30) @(posedge clk);
    #1;
    iob_read(R_STATUS, r); chk("t6_busy_status", r, 32'h8000_0000 | (32'd16 << 2) | 32'h2);
    tready = 1'b1;
    wait_drain(200);
    iob_read(R_STATUS, r); chk("t6_idle_status", r, 32'h1);
`else
    iob_write(R_PATTERN, 32'd5);
    iob_read(R_PATTERN, r); chk("t6_reg4_rd", r, 32'h0);
    iob_read(R_STATUS, r); chk("t6_status", r, 32'h1);
`endif

    // Reset with a partial frame queued.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) iob_write(R_DATA, 32'h400 + i);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t7_tvalid", tvalid, 1'b0);
    chk("t7_tlast", tlast, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    iob_read(R_STATUS, r); chk("t7_status", r, 32'h1);
    iob_read(R_COUNT, r);  chk("t7_count", r, 32'h0);
    tready = 1'b1;
    iob_write(R_LAST, 32'h77);
    wait_drain(50);
    iob_read(R_COUNT, r);  chk("t7_post_count", r, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
